// File: rtl/ex_pkg.sv
// Shared widths, operation codes and divider state encodings for the execute stage.
package ex_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;

    localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'h24;
    localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'h25;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'h26;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'h27;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'h7C;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'h02;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'h03;
    localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'h21;
    localparam logic [AluOpBus-1:0] EXE_SUBU_OP = 8'h23;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'h2A;
    localparam logic [AluOpBus-1:0] EXE_SLTU_OP = 8'h2B;
    localparam logic [AluOpBus-1:0] EXE_MFHI_OP = 8'h10;
    localparam logic [AluOpBus-1:0] EXE_MFLO_OP = 8'h12;
    localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'h1A;
    localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'h1B;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Magnitude of a possibly-signed operand; 0x80000000 maps to itself.
    function automatic logic [RegBus-1:0] magnitude(input logic is_signed, input logic [RegBus-1:0] v);
        return (is_signed && v[RegBus-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_if.sv
// Decode/execute operands in, execute/memory results out, plus the flush from ctrl.
interface ex_if;
    import ex_pkg::*;

    logic                  flush;
    logic [AluOpBus-1:0]   aluop_i;
    logic [AluSelBus-1:0]  alusel_i;
    logic [RegBus-1:0]     reg1_i;
    logic [RegBus-1:0]     reg2_i;
    logic [RegAddrBus-1:0] wd_i;
    logic                  wreg_i;
    logic [RegBus-1:0]     hi_i;
    logic [RegBus-1:0]     lo_i;
    logic                  mem_whilo_i;
    logic [RegBus-1:0]     mem_hi_i;
    logic [RegBus-1:0]     mem_lo_i;
    logic [RegAddrBus-1:0] wd_o;
    logic                  wreg_o;
    logic [RegBus-1:0]     wdata_o;
    logic                  whilo_o;
    logic [RegBus-1:0]     hi_o;
    logic [RegBus-1:0]     lo_o;
    logic                  stallreq_o;

    modport master (
        output flush, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
               hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  flush, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
               hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider, one quotient bit per cycle: result 33 cycles after start
// (2 for a zero divisor), held in END until start drops; annul aborts at any time.
module ex_div
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [RegBus-1:0] opdata1_i,
    input  logic [RegBus-1:0] opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [63:0]       result_o,
    output logic              ready_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // [64:32] partial remainder, [31:0] unconsumed dividend bits / quotient bits
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic [33:0] diff;
    logic [64:0] step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        diff    = {dividend_q[64:32], dividend_q[31]} - {2'b00, divisor_q};
        step    = diff[33] ? {dividend_q[63:0], 1'b0}
                           : {diff[32:0], dividend_q[30:0], 1'b1};
        quo_fix = neg_quo_q ? (~step[31:0] + 32'd1) : step[31:0];
        rem_fix = neg_rem_q ? (~step[63:32] + 32'd1) : step[63:32];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;

        case (state_q)
            DivFree: begin
                if (start_i == DivStart) begin
                    if (opdata2_i == '0) begin
                        state_d    = DivByZero;
                        dividend_d = '0;
                    end else begin
                        state_d    = DivOn;
                        cnt_d      = '0;
                        dividend_d = {33'd0, magnitude(signed_div_i, opdata1_i)};
                        divisor_d  = magnitude(signed_div_i, opdata2_i);
                        neg_quo_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d  = signed_div_i & opdata1_i[31];
                    end
                end
            end
            DivOn: begin
                if (cnt_q == 6'd31) begin
                    // Sign correction folds into the final step.
                    dividend_d = {1'b0, rem_fix, quo_fix};
                    cnt_d      = '0;
                    state_d    = DivEnd;
                end else begin
                    dividend_d = step;
                    cnt_d      = cnt_q + 6'd1;
                end
            end
            DivByZero: begin
                state_d = DivEnd;
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: begin
                state_d = DivFree;
            end
        endcase

        if (annul_i) begin
            state_d = DivFree;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
    assign result_o = dividend_q[63:0];

endmodule

// File: rtl/ex.sv
// OpenMIPS execute stage: combinational ALU results in the issue cycle; divides stall
// the pipeline via stallreq_o until the divider delivers hi/lo.
module ex
    import ex_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic              is_div;
    logic [RegBus-1:0] logic_res;
    logic [RegBus-1:0] shift_res;
    logic [RegBus-1:0] arith_res;
    logic [RegBus-1:0] move_res;
    logic [RegBus-1:0] wdata;
    logic [RegBus-1:0] hi_src;
    logic [RegBus-1:0] lo_src;
    logic              slt_res;
    logic              sltu_res;
    logic              div_start;
    logic              div_ready;
    logic [63:0]       div_result;

    assign is_div   = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
    assign hi_src   = bus.mem_whilo_i ? bus.mem_hi_i : bus.hi_i;
    assign lo_src   = bus.mem_whilo_i ? bus.mem_lo_i : bus.lo_i;
    assign slt_res  = $signed(bus.reg1_i) < $signed(bus.reg2_i);
    assign sltu_res = bus.reg1_i < bus.reg2_i;

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (bus.aluop_i)
            EXE_AND_OP:  logic_res = bus.reg1_i & bus.reg2_i;
            EXE_OR_OP:   logic_res = bus.reg1_i | bus.reg2_i;
            EXE_XOR_OP:  logic_res = bus.reg1_i ^ bus.reg2_i;
            EXE_NOR_OP:  logic_res = ~(bus.reg1_i | bus.reg2_i);
            EXE_SLL_OP:  shift_res = bus.reg2_i << bus.reg1_i[4:0];
            EXE_SRL_OP:  shift_res = bus.reg2_i >> bus.reg1_i[4:0];
            EXE_SRA_OP:  shift_res = $unsigned($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
            EXE_ADDU_OP: arith_res = bus.reg1_i + bus.reg2_i;
            EXE_SUBU_OP: arith_res = bus.reg1_i - bus.reg2_i;
            EXE_SLT_OP:  arith_res = {31'd0, slt_res};
            EXE_SLTU_OP: arith_res = {31'd0, sltu_res};
            EXE_MFHI_OP: move_res  = hi_src;
            EXE_MFLO_OP: move_res  = lo_src;
            default: ;
        endcase
    end

    always_comb begin
        wdata = '0;
        case (bus.alusel_i)
            EXE_RES_LOGIC: wdata = logic_res;
            EXE_RES_SHIFT: wdata = shift_res;
            EXE_RES_MOVE:  wdata = move_res;
            EXE_RES_ARITH: wdata = arith_res;
            default:       wdata = '0;
        endcase
    end

    // start drops while ready is high, so END always returns to IDLE before a new divide.
    assign div_start = is_div & ~div_ready & ~bus.flush;

    ex_div u_div (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (bus.aluop_i == EXE_DIV_OP),
        .opdata1_i    (bus.reg1_i),
        .opdata2_i    (bus.reg2_i),
        .start_i      (div_start),
        .annul_i      (bus.flush),
        .result_o     (div_result),
        .ready_o      (div_ready)
    );

    always_comb begin
        bus.wd_o       = bus.wd_i;
        bus.wreg_o     = bus.wreg_i & ~is_div;
        bus.wdata_o    = wdata;
        bus.whilo_o    = is_div & div_ready;
        bus.hi_o       = bus.whilo_o ? div_result[63:32] : '0;
        bus.lo_o       = bus.whilo_o ? div_result[31:0] : '0;
        bus.stallreq_o = is_div & ~div_ready;
        if (rst) begin
            bus.wd_o       = '0;
            bus.wreg_o     = 1'b0;
            bus.wdata_o    = '0;
            bus.whilo_o    = 1'b0;
            bus.hi_o       = '0;
            bus.lo_o       = '0;
            bus.stallreq_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: directed and random ALU ops, divides,
// flush and reset aborts, all against a behavioural reference model.
module tb_ex;
    import ex_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_if bus ();

    ex dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [7:0] OPS [13] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
                                        8'h21, 8'h23, 8'h2A, 8'h2B, 8'h10, 8'h12};

    typedef struct packed {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        mw;
        logic [31:0] mhi;
        logic [31:0] mlo;
        logic [31:0] exp;
    } alu_vec_t;

    // Reference: class an opcode belongs to and the value it produces.
    function automatic void alu_model(input logic [7:0] op, input logic [31:0] a, b, hi, lo,
                                      input logic mw, input logic [31:0] mhi, mlo,
                                      output logic [2:0] cls, output logic [31:0] v);
        longint sb;
        cls = 3'd0;
        v   = 32'd0;
        sb  = longint'($signed(b));
        case (op)
            8'h24: begin cls = 3'd1; v = a & b; end
            8'h25: begin cls = 3'd1; v = a | b; end
            8'h26: begin cls = 3'd1; v = a ^ b; end
            8'h27: begin cls = 3'd1; v = ~(a | b); end
            8'h7C: begin cls = 3'd2; v = b << a[4:0]; end
            8'h02: begin cls = 3'd2; v = b >> a[4:0]; end
            8'h03: begin cls = 3'd2; v = 32'(sb >>> a[4:0]); end
            8'h21: begin cls = 3'd4; v = a + b; end
            8'h23: begin cls = 3'd4; v = a - b; end
            8'h2A: begin cls = 3'd4; v = (longint'($signed(a)) < sb) ? 32'd1 : 32'd0; end
            8'h2B: begin cls = 3'd4; v = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0; end
            8'h10: begin cls = 3'd3; v = mw ? mhi : hi; end
            8'h12: begin cls = 3'd3; v = mw ? mlo : lo; end
            default: ;
        endcase
    endfunction

    function automatic void div_model(input logic sgn, input logic [31:0] a, b,
                                      output logic [31:0] q, r);
        longint na, nb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            if (sgn) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            q = 32'(na / nb);
            r = 32'(na % nb);
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.flush       = 1'b0;
        bus.aluop_i     = 8'h00;
        bus.alusel_i    = 3'd0;
        bus.reg1_i      = '0;
        bus.reg2_i      = '0;
        bus.wd_i        = '0;
        bus.wreg_i      = 1'b0;
        bus.hi_i        = '0;
        bus.lo_i        = '0;
        bus.mem_whilo_i = 1'b0;
        bus.mem_hi_i    = '0;
        bus.mem_lo_i    = '0;
    endtask

    // Issues one divide in the current cycle and follows it to its result.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, b, input string tag);
        logic [31:0] eq, er;
        int  lat, exp_lat;
        bit  done;
        div_model(op == 8'h1A, a, b, eq, er);
        exp_lat         = (b == 32'd0) ? 2 : 33;
        bus.flush       = 1'b0;
        bus.aluop_i     = op;
        bus.alusel_i    = 3'd0;
        bus.reg1_i      = a;
        bus.reg2_i      = b;
        bus.wd_i        = 5'd9;
        bus.wreg_i      = 1'b1;
        bus.mem_whilo_i = 1'b0;
        done = 1'b0;
        lat  = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            checks++;
            if (bus.wreg_o !== 1'b0) begin
                errors++;
                $display("FAIL %s wreg_o cyc %0d: got %b want 0", tag, c, bus.wreg_o);
            end
            if (bus.whilo_o === 1'b1) begin
                done = 1'b1;
                lat  = c;
            end else begin
                checks++;
                if (bus.stallreq_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s stallreq_o cyc %0d: got %b want 1", tag, c, bus.stallreq_o);
                end
                next_cycle();
                bus.reg1_i = $urandom;
                bus.reg2_i = $urandom;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no whilo_o within 60 cycles, want at %0d", tag, exp_lat);
        end else begin
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
            end
            checks++;
            if (bus.lo_o !== eq) begin
                errors++;
                $display("FAIL %s lo_o: got %h want %h", tag, bus.lo_o, eq);
            end
            checks++;
            if (bus.hi_o !== er) begin
                errors++;
                $display("FAIL %s hi_o: got %h want %h", tag, bus.hi_o, er);
            end
            checks++;
            if (bus.stallreq_o !== 1'b0) begin
                errors++;
                $display("FAIL %s stallreq_o at result: got %b want 0", tag, bus.stallreq_o);
            end
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.aluop_i     = 8'h1B;
        bus.alusel_i    = 3'd1;
        bus.reg1_i      = 32'h1234_5678;
        bus.reg2_i      = 32'd5;
        bus.wd_i        = 5'd7;
        bus.wreg_i      = 1'b1;
        bus.mem_whilo_i = 1'b1;
        bus.mem_hi_i    = 32'hDEAD;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
                errors++;
                $display("FAIL reset outputs cyc %0d: got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b want all 0",
                         c, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o);
            end
            next_cycle();
        end
        drive_idle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_alu_directed();
        alu_vec_t v[$];
        v.push_back('{8'h25, 3'd1, 32'h0000FFFF, 32'h00FF00FF, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'h00FFFFFF});
        v.push_back('{8'h03, 3'd2, 32'd4, 32'hF0000000, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'hFF000000});
        v.push_back('{8'h2A, 3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd1});
        v.push_back('{8'h2B, 3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0});
        v.push_back('{8'h23, 3'd4, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF});
        v.push_back('{8'h10, 3'd3, 32'd0, 32'd0, 32'hAAAA, 32'd0, 1'b1, 32'h1234, 32'd0, 32'h1234});
        v.push_back('{8'h12, 3'd3, 32'd0, 32'd0, 32'd0, 32'h5555, 1'b0, 32'd0, 32'h7777, 32'h5555});
        v.push_back('{8'h7C, 3'd2, 32'd31, 32'd3, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'h80000000});
        v.push_back('{8'h02, 3'd2, 32'd8, 32'hF0000000, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'h00F00000});
        v.push_back('{8'h27, 3'd1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF});
        v.push_back('{8'h25, 3'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0});
        v.push_back('{8'h55, 3'd1, 32'hFFFF, 32'h1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0});
        v.push_back('{8'h21, 3'd4, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd1});
        foreach (v[i]) begin
            bus.aluop_i     = v[i].op;
            bus.alusel_i    = v[i].sel;
            bus.reg1_i      = v[i].r1;
            bus.reg2_i      = v[i].r2;
            bus.hi_i        = v[i].hi;
            bus.lo_i        = v[i].lo;
            bus.mem_whilo_i = v[i].mw;
            bus.mem_hi_i    = v[i].mhi;
            bus.mem_lo_i    = v[i].mlo;
            bus.wd_i        = 5'(i + 1);
            bus.wreg_i      = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.wdata_o !== v[i].exp) begin
                errors++;
                $display("FAIL directed_alu[%0d] op %h wdata_o: got %h want %h", i, v[i].op, bus.wdata_o, v[i].exp);
            end
            checks++;
            if (bus.wd_o !== 5'(i + 1) || bus.wreg_o !== 1'b1) begin
                errors++;
                $display("FAIL directed_alu[%0d] wd_o/wreg_o: got %h/%b want %h/1", i, bus.wd_o, bus.wreg_o, 5'(i + 1));
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_alu_random();
        logic [7:0]  op;
        logic [2:0]  sel, cls;
        logic [31:0] a, b, v, exp;
        for (int i = 0; i < 200; i++) begin
            op = OPS[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) == 0) op = 8'($urandom);
            if (op == 8'h1A || op == 8'h1B) op = 8'h00;
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'h8000_0000;
            bus.aluop_i     = op;
            bus.reg1_i      = a;
            bus.reg2_i      = b;
            bus.hi_i        = $urandom;
            bus.lo_i        = $urandom;
            bus.mem_whilo_i = 1'($urandom);
            bus.mem_hi_i    = $urandom;
            bus.mem_lo_i    = $urandom;
            bus.wd_i        = 5'($urandom);
            bus.wreg_i      = 1'($urandom);
            alu_model(op, a, b, bus.hi_i, bus.lo_i, bus.mem_whilo_i, bus.mem_hi_i, bus.mem_lo_i, cls, v);
            sel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : cls;
            bus.alusel_i = sel;
            exp = (sel == cls && cls != 3'd0) ? v : 32'd0;
            @(negedge clk);
            checks++;
            if (bus.wdata_o !== exp) begin
                errors++;
                $display("FAIL random_alu[%0d] op %h sel %0d a %h b %h wdata_o: got %h want %h",
                         i, op, sel, a, b, bus.wdata_o, exp);
            end
            checks++;
            if (bus.wd_o !== bus.wd_i || bus.wreg_o !== bus.wreg_i) begin
                errors++;
                $display("FAIL random_alu[%0d] wd_o/wreg_o: got %h/%b want %h/%b",
                         i, bus.wd_o, bus.wreg_o, bus.wd_i, bus.wreg_i);
            end
            checks++;
            if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
                errors++;
                $display("FAIL random_alu[%0d] whilo_o/stallreq_o: got %b/%b want 0/0",
                         i, bus.whilo_o, bus.stallreq_o);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_div_directed();
        run_div(8'h1A, 32'hFFFFFFF9, 32'd2, "div_neg7_by_2");
        run_div(8'h1B, 32'hFFFFFFFF, 32'h10, "divu_max_by_16");
        run_div(8'h1A, 32'd5, 32'd0, "div_by_zero");
        run_div(8'h1A, 32'h80000000, 32'hFFFFFFFF, "div_min_by_neg1");
        run_div(8'h1A, 32'd7, 32'hFFFFFFFE, "div_7_by_neg2");
        run_div(8'h1B, 32'h80000000, 32'hFFFFFFFF, "divu_big_divisor");
        drive_idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 8'h1A : 8'h1B;
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = 32'd0 - 32'($urandom_range(1, 9));
            endcase
            run_div(op, a, b, $sformatf("b2b_div[%0d]", i));
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_flush();
        int pulses;
        bus.aluop_i = 8'h1A;
        bus.reg1_i  = 32'hFFFFFF9C;
        bus.reg2_i  = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.stallreq_o !== 1'b1) begin
                errors++;
                $display("FAIL flush pre stallreq_o cyc %0d: got %b want 1", c, bus.stallreq_o);
            end
            next_cycle();
        end
        bus.flush = 1'b1;
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus.stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL flush stallreq_o after flush: got %b want 0", bus.stallreq_o);
        end
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            @(negedge clk);
            if (bus.whilo_o !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL flush whilo_o pulses: got %0d want 0", pulses);
        end
        next_cycle();
        run_div(8'h1B, 32'd100, 32'd7, "divu_after_flush");
        drive_idle();
        next_cycle();
    endtask

    task automatic test_rst_mid_div();
        int pulses;
        bus.aluop_i = 8'h1B;
        bus.reg1_i  = 32'd1000;
        bus.reg2_i  = 32'd3;
        bus.wd_i    = 5'd4;
        bus.wreg_i  = 1'b1;
        for (int c = 0; c < 5; c++) next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
                errors++;
                $display("FAIL rst_mid_div outputs cyc %0d: got wd=%h wreg=%b stall=%b whilo=%b want all 0",
                         c, bus.wd_o, bus.wreg_o, bus.stallreq_o, bus.whilo_o);
            end
            next_cycle();
        end
        drive_idle();
        rst    = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.whilo_o !== 1'b0) pulses++;
            next_cycle();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rst_mid_div whilo_o pulses: got %0d want 0", pulses);
        end
        run_div(8'h1A, 32'hFFFFFC18, 32'd7, "div_after_rst");
        drive_idle();
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive_idle();
        next_cycle();
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_div_directed();
        test_back_to_back();
        test_flush();
        test_rst_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex.md
# ex

- Execute stage of the OpenMIPS five-stage pipeline.
- Consumes the decoded operation and operands produced by decode, after the decode/execute pipeline register.
- Computes logic, shift, arithmetic, move-from-HI/LO and divide results.
- Passes the results to the execute/memory pipeline register. Divides run on an iterative sequential divider and stall the pipeline until done.

## Interface
Parameters: none. All widths come from the shared defines file: `RegBus` 32b, `RegAddrBus` 5b, `AluOpBus` 8b, `AluSelBus` 3b.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  from ctrl; aborts any in-flight divide
- aluop_i  in  8  operation code
- alusel_i  in  3  result class
- reg1_i  in  32  operand 1 (shift amount in [4:0] for shifts)
- reg2_i  in  32  operand 2
- wd_i  in  5  destination register
- wreg_i  in  1  destination write enable
- hi_i, lo_i  in  32 each  architectural HI/LO
- mem_whilo_i  in  1  HI/LO write pending in the mem stage
- mem_hi_i, mem_lo_i  in  32 each  values for that pending write
- wd_o  out  5  = wd_i
- wreg_o  out  1  = wreg_i
- wdata_o  out  32  GPR result
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  32 each  HI/LO write data
- stallreq_o  out  1  stall request to ctrl

## Operation
- **Result classes** (alusel): NOP 000, LOGIC 001, SHIFT 010, MOVE 011, ARITH 100. In NOP class, wdata_o = 0.
- **aluop codes:**
  - Logic: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - Shifts: SLL 0x7C, SRL 0x02, SRA 0x03.
  - Arithmetic: ADDU 0x21, SUBU 0x23, SLT 0x2A, SLTU 0x2B.
  - HI/LO: MFHI 0x10, MFLO 0x12.
  - Divide: DIV 0x1A, DIVU 0x1B.
  - Unknown codes give 0.
- **Shifts:** operate on reg2_i by reg1_i[4:0]. SRA fills with reg2_i[31].
- **ADDU/SUBU:** modulo 2^32, no overflow trap.
- **Compares:** SLT is a signed compare, SLTU unsigned; result is 0 or 1.
- **MFHI/MFLO:** use mem_hi_i/mem_lo_i when mem_whilo_i = 1, otherwise hi_i/lo_i.
- **DIV/DIVU:**
  - wreg_o is forced to 0.
  - lo_o = quotient, hi_o = remainder, whilo_o = 1 only in the cycle the result is ready.
- **Signed divide:**
  - Divide the magnitudes.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- **Divide by zero:** quotient = remainder = 0, delivered on the fast path.
- **div sub-module FSM:**
  - IDLE: on start, go to DIVBYZERO if divisor = 0, else ON with cnt = 0.
  - ON: one restoring shift/subtract step per cycle; cnt 0..31; after the step at cnt = 31, go to END.
  - DIVBYZERO: go to END next cycle.
  - END: ready = 1 with the result; go to IDLE when start = 0.
  - From any state, rst or flush goes to IDLE with ready = 0.
- **Control toward div:**
  - start = (aluop is DIV/DIVU) & ~ready & ~flush.
  - signed = (aluop == DIV).
  - Operands are latched by div on IDLE → ON; later changes to reg1_i/reg2_i are ignored.
- **stallreq_o** = (aluop is DIV/DIVU) & ~ready.

## Timing
- Everything except div is combinational; results are valid in the same cycle aluop arrives.
- Divide issued in cycle T, nonzero divisor:
  - stallreq_o = 1 in T..T+32.
  - ready, whilo_o = 1 and stallreq_o = 0 in T+33 (the END state).
  - div is back in IDLE at T+34.
- Divide by zero: stallreq_o = 1 in T..T+1; result in T+2.
- Back-to-back divides: the second start is only seen after div has returned to IDLE (END → IDLE takes one cycle, because start drops while ready = 1). There is no lost or duplicated result.
- **Reset values** while rst = 1: all outputs 0, div in IDLE, ready = 0, cnt = 0.
- **rst or flush mid-divide:** the partial result is discarded and whilo_o is never asserted for it. The next start begins fresh.

## Structure
- aluop/alusel codes and state encodings live in the shared defines file:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivStart, DivStop, DivResultReady, DivResultNotReady.
- One sub-module, `div`:
  - Ports: clk, rst, signed_div_i, opdata1_i, opdata2_i, start_i, annul_i (driven by flush), result_o[63:0] (hi:lo), ready_o.
  - Internal state: 65-bit dividend/partial-remainder register, 6-bit counter, 2-bit state.
- ex instantiates div and holds all combinational muxing.

## Test plan
- OR: reg1 = 0x0000FFFF, reg2 = 0x00FF00FF → wdata_o = 0x00FFFFFF. SRA: amount 4, reg2 = 0xF0000000 → 0xFF000000.
- SLT: reg1 = 0xFFFFFFFF, reg2 = 1 → 1. SLTU with the same operands → 0. SUBU: 0 − 1 → 0xFFFFFFFF.
- DIV −7 / 2 → in cycle T+33, lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF, whilo_o = 1; stallreq_o high for exactly 33 cycles.
- DIVU 0xFFFFFFFF / 0x10 → lo_o = 0x0FFFFFFF, hi_o = 0xF. DIV by 0 → hi_o = lo_o = 0 at T+2.
- flush at T+10 during a divide → stallreq_o drops, no whilo_o pulse. A following DIVU 100 / 7 → lo_o = 14, hi_o = 2 at its own T+33.
- MFHI with mem_whilo_i = 1, mem_hi_i = 0x1234 and hi_i = 0xAAAA → wdata_o = 0x1234. rst asserted mid-divide → all outputs 0 on the next edge.
